// File: rtl/alu_muldiv_pkg.sv
// Shared definitions for the alu_muldiv_seq execute unit: opcode encodings,
// controller state type and the mul/div opcode classifier.
package alu_muldiv_pkg;

    typedef logic [3:0] op_t;

    localparam op_t OP_ADD   = 4'd0;
    localparam op_t OP_SUB   = 4'd1;
    localparam op_t OP_AND   = 4'd2;
    localparam op_t OP_OR    = 4'd3;
    localparam op_t OP_XOR   = 4'd4;
    localparam op_t OP_NOR   = 4'd5;
    localparam op_t OP_SLT   = 4'd6;
    localparam op_t OP_SLTU  = 4'd7;
    localparam op_t OP_MULT  = 4'd8;
    localparam op_t OP_MULTU = 4'd9;
    localparam op_t OP_DIV   = 4'd10;
    localparam op_t OP_DIVU  = 4'd11;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    function automatic logic is_muldiv(input op_t op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative datapath: shift-add multiply and restoring divide on operand
// magnitudes, one bit per cycle, with sign fix-up applied to the final step.
module alu_muldiv_iter
    import alu_muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_op,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH);

    logic               busy_q;
    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opb_q;
    logic [WIDTH-1:0]   a_q;
    logic               is_div_q;
    logic               neg_lo_q;
    logic               neg_rem_q;
    logic               bzero_q;

    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     trial;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem;

    assign a_neg = signed_op & a[WIDTH-1];
    assign b_neg = signed_op & b[WIDTH-1];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;

    // acc holds {partial product, multiplier} for mul and {remainder, quotient} for div.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        acc_d = acc_q;
        sum   = '0;
        trial = '0;
        if (is_div_q) begin
            trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opb_q};
            if (!trial[WIDTH]) begin
                acc_d = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
            end
        end else begin
            sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
            acc_d = {sum, acc_q[WIDTH-1:1]};
        end
    end

    assign done = busy_q && (cnt_q == CW'(WIDTH - 1));
    assign prod = neg_lo_q ? -acc_d : acc_d;
    assign quo  = neg_lo_q ? -acc_d[WIDTH-1:0] : acc_d[WIDTH-1:0];
    assign rem  = neg_rem_q ? -acc_d[2*WIDTH-1:WIDTH] : acc_d[2*WIDTH-1:WIDTH];

    always_comb begin
        hi       = prod[2*WIDTH-1:WIDTH];
        lo       = prod[WIDTH-1:0];
        div_zero = 1'b0;
        if (is_div_q) begin
            hi = rem;
            lo = quo;
            if (bzero_q) begin
                hi       = a_q;
                lo       = '1;
                div_zero = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q    <= 1'b0;
            cnt_q     <= '0;
            acc_q     <= '0;
            opb_q     <= '0;
            a_q       <= '0;
            is_div_q  <= 1'b0;
            neg_lo_q  <= 1'b0;
            neg_rem_q <= 1'b0;
            bzero_q   <= 1'b0;
        end else if (start) begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            busy_q    <= 1'b1;
            cnt_q     <= '0;
            acc_q     <= {{WIDTH{1'b0}}, a_mag};
            opb_q     <= b_mag;
            a_q       <= a;
            is_div_q  <= is_div;
            neg_lo_q  <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            bzero_q   <= is_div && (b == '0);
        end else if (busy_q) begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + 1'b1;
            if (done) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_muldiv_seq.sv
// EX-stage execute unit: single-cycle ALU ops plus iterative MULT/DIV behind a
// valid/ready handshake. Define ALU_OVF_EN to add the registered ovf output.
module alu_muldiv_seq
    import alu_muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int OPW   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPW-1:0]   op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             zero,
    output logic             div_zero
`ifdef ALU_OVF_EN
    ,
    output logic             ovf
`endif
);

    state_t           state_q;
    logic [WIDTH-1:0] y_q, hi_q, lo_q;
    logic             zero_q, dz_q;

    op_t              op_c;
    logic             op_hi_set;
    logic             md_op;
    logic [WIDTH-1:0] sum_v, diff_v, alu_y;
    logic             it_done, it_dz;
    logic [WIDTH-1:0] it_hi, it_lo;

    // Opcodes wider than four bits with any upper bit set fall into the unknown-op class.
    assign op_c = op_t'(op);
    if (OPW > 4) begin : g_op_hi
        assign op_hi_set = |op[OPW-1:4];
    end else begin : g_op_lo
        assign op_hi_set = 1'b0;
    end

    assign md_op  = is_muldiv(op_c) && !op_hi_set;
    assign sum_v  = a + b;
    assign diff_v = a - b;

    always_comb begin
        alu_y = '0;
        case (op_c)
            OP_ADD:  alu_y = sum_v;
            OP_SUB:  alu_y = diff_v;
            OP_AND:  alu_y = a & b;
            OP_OR:   alu_y = a | b;
            OP_XOR:  alu_y = a ^ b;
            OP_NOR:  alu_y = ~(a | b);
            OP_SLT:  alu_y = WIDTH'($signed(a) < $signed(b));
            OP_SLTU: alu_y = WIDTH'(a < b);
            default: alu_y = '0;
        endcase
        if (op_hi_set) begin
            alu_y = '0;
        end
    end

`ifdef ALU_OVF_EN
    logic alu_ovf, ovf_q;

    always_comb begin
        alu_ovf = 1'b0;
        if (!op_hi_set && op_c == OP_ADD) begin
            alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum_v[WIDTH-1] != a[WIDTH-1]);
        end else if (!op_hi_set && op_c == OP_SUB) begin
            alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff_v[WIDTH-1] != a[WIDTH-1]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (state_q == IDLE && in_valid) begin
            ovf_q <= alu_ovf;
        end
    end

    assign ovf = ovf_q;
`endif

    alu_muldiv_iter #(
        .WIDTH(WIDTH)
    ) u_iter (
        .clk      (clk),
        .rst      (rst),
        .start    (state_q == IDLE && in_valid && md_op),
        .signed_op(op_c == OP_MULT || op_c == OP_DIV),
        .is_div   (op_c == OP_DIV || op_c == OP_DIVU),
        .a        (a),
        .b        (b),
        .done     (it_done),
        .hi       (it_hi),
        .lo       (it_lo),
        .div_zero (it_dz)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            y_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            zero_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        if (md_op) begin
                            state_q <= BUSY;
                        end else begin
                            state_q <= DONE;
                            y_q     <= alu_y;
                            hi_q    <= '0;
                            lo_q    <= '0;
                            zero_q  <= (alu_y == '0);
                            dz_q    <= 1'b0;
                        end
                    end
                end
                BUSY: begin
                    if (it_done) begin
                        state_q <= DONE;
                        y_q     <= '0;
                        hi_q    <= it_hi;
                        lo_q    <= it_lo;
                        zero_q  <= ({it_hi, it_lo} == '0);
                        dz_q    <= it_dz;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign y         = y_q;
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign zero      = zero_q;
    assign div_zero  = dz_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed bench for alu_muldiv_seq with hand-computed expected results.
module tb_alu_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  op = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] y, hi, lo;
    logic        zero, div_zero;
`ifdef ALU_OVF_EN
    logic        ovf;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    alu_muldiv_seq #(.WIDTH(32), .OPW(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .y        (y),
        .hi       (hi),
        .lo       (lo),
        .zero     (zero),
        .div_zero (div_zero)
`ifdef ALU_OVF_EN
        ,
        .ovf      (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Present one op in IDLE; lat counts rising edges from the accept edge to out_valid.
    task automatic run_op(input logic [3:0] o, input logic [31:0] av, input logic [31:0] bv,
                          output int lat);
        op = o; a = av; b = bv; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic retire();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("retire.in_ready", 64'(in_ready), 64'd1);
    endtask

    task automatic alu_vec(input string tag, input logic [3:0] o, input logic [31:0] av,
                           input logic [31:0] bv, input logic [31:0] ey, input logic ez);
        int lat;
        run_op(o, av, bv, lat);
        check({tag, ".lat"}, 64'(lat), 64'd1);
        check({tag, ".y"}, 64'(y), 64'(ey));
        check({tag, ".hilo"}, {hi, lo}, 64'd0);
        check({tag, ".zero"}, 64'(zero), 64'(ez));
        retire();
    endtask

    task automatic md_vec(input string tag, input logic [3:0] o, input logic [31:0] av,
                          input logic [31:0] bv, input logic [31:0] ehi, input logic [31:0] elo,
                          input logic edz);
        int lat;
        run_op(o, av, bv, lat);
        check({tag, ".lat"}, 64'(lat), 64'd33);
        check({tag, ".hi"}, 64'(hi), 64'(ehi));
        check({tag, ".lo"}, 64'(lo), 64'(elo));
        check({tag, ".y"}, 64'(y), 64'd0);
        check({tag, ".zero"}, 64'(zero), 64'({ehi, elo} == 64'd0));
        check({tag, ".dz"}, 64'(div_zero), 64'(edz));
        retire();
    endtask

    initial begin
        int lat;
        logic seen;

        repeat (3) @(posedge clk);
        #1;
        check("rst.out_valid", 64'(out_valid), 64'd0);
        check("rst.outs", {y, hi}, 64'd0);
        check("rst.lo_flags", {lo, 30'd0, zero, div_zero}, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst.in_ready", 64'(in_ready), 64'd1);

        // Single-cycle ALU ops.
`ifdef ALU_OVF_EN
        run_op(4'd0, 32'h7FFF_FFFF, 32'd1, lat);
        check("add_ovf.ovf", 64'(ovf), 64'd1);
        retire();
`endif
        alu_vec("add_ovf", 4'd0, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0);
        alu_vec("sub_eq", 4'd1, 32'd5, 32'd5, 32'd0, 1'b1);
        alu_vec("and", 4'd2, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0);
        alu_vec("or", 4'd3, 32'h1200_0034, 32'h0056_7800, 32'h1256_7834, 1'b0);
        alu_vec("xor", 4'd4, 32'hFFFF_0000, 32'hFF00_FF00, 32'h00FF_FF00, 1'b0);
        alu_vec("nor", 4'd5, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b0);
        alu_vec("slt", 4'd6, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0);
        alu_vec("sltu", 4'd7, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1);
        alu_vec("unknown", 4'd12, 32'd9, 32'd9, 32'd0, 1'b1);

        // Iterative multiply / divide.
        md_vec("mult", 4'd8, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        md_vec("multu", 4'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        md_vec("mult0", 4'd8, 32'd0, 32'd5, 32'd0, 32'd0, 1'b0);
        md_vec("div", 4'd10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        md_vec("divu", 4'd11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        md_vec("divu_z", 4'd11, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, 1'b1);
        md_vec("div_mn", 4'd10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);

        // Backpressure: result held, new requests ignored while DONE.
        run_op(4'd0, 32'd2, 32'd3, lat);
        op = 4'd1; a = 32'd9; b = 32'd1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp.y", 64'(y), 64'd5);
            check("bp.valid_ready", {62'd0, out_valid, in_ready}, 64'd2);
        end
        in_valid = 1'b0;
        retire();
        seen = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            seen |= out_valid;
        end
        check("bp.no_queue", 64'(seen), 64'd0);

        // Retire and new request together: accept happens one cycle later.
        run_op(4'd0, 32'd10, 32'd20, lat);
        check("sim.y0", 64'(y), 64'd30);
        op = 4'd0; a = 32'd1; b = 32'd1; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("sim.idle", {62'd0, out_valid, in_ready}, 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("sim.valid", 64'(out_valid), 64'd1);
        check("sim.y", 64'(y), 64'd2);

        // Reset in the middle of a divide aborts it.
        retire();
        op = 4'd10; a = 32'd100; b = 32'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort.outs", {y, lo}, 64'd0);
        check("abort.flags", {hi, 29'd0, zero, div_zero, out_valid}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            seen |= out_valid;
        end
        check("abort.no_result", 64'(seen), 64'd0);
        alu_vec("post_rst_add", 4'd0, 32'd2, 32'd3, 32'd5, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
